// File: rtl/rt_output_arbiter.sv
// rt_output_arbiter: per-output wormhole arbiter for one Corner_Router output.
// Shares one output between N_REQ requesters in round-robin order. A requester
// keeps the output from the head flit to the tail flit of its packet, and
// flits from different packets are never interleaved. The output flit is held
// in a register.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_ni       asynchronous reset, active low
//   in_valid_i   requester i presents a flit
//   in_data_i    flit of requester i at [i*n +: n]
//   in_tail_i    flit of requester i is the last flit of its packet
//   in_ready_o   flit of requester i is accepted this cycle (combinational)
//   out_valid_o  registered flit valid toward the link
//   out_data_o   registered flit
//   out_tail_o   registered tail marker
//   out_ready_i  downstream accepts the output flit this cycle
//   grant_o      one-hot current owner; 0 while idle
//   busy_o       1 while a packet owns the output
module rt_output_arbiter #(
  parameter int unsigned n     = 32,
  parameter int unsigned N_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   in_valid_i,
  input  logic [N_REQ*n-1:0] in_data_i,
  input  logic [N_REQ-1:0]   in_tail_i,
  output logic [N_REQ-1:0]   in_ready_o,
  output logic               out_valid_o,
  output logic [n-1:0]       out_data_o,
  output logic               out_tail_o,
  input  logic               out_ready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [N_REQ-1:0]   grant_q;
  logic               busy_q;
  logic               out_valid_q;
  logic [n-1:0]       out_data_q;
  logic               out_tail_q;

  logic [IDX_W-1:0]   pick_c;
  logic [IDX_W-1:0]   cand_c;
  logic               any_c;
  logic [n-1:0]       sel_data_c;
  logic               sel_tail_c;
  logic               sel_valid_c;
  logic               locked_c;
  logic               free_c;
  logic               xfer_c;

  // Round-robin search starting just after the last packet's owner.
  always_comb begin
    pick_c = rr_ptr_q;
    cand_c = '0;
    any_c  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = IDX_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!any_c && in_valid_i[cand_c]) begin
        pick_c = cand_c;
        any_c  = 1'b1;
      end
    end
  end

  // Only the current owner's flit is ever selected.
  always_comb begin
    sel_data_c = '0;
    sel_tail_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx_q == IDX_W'(i)) begin
        sel_data_c = in_data_i[i*n +: n];
        sel_tail_c = in_tail_i[i];
      end
    end
  end

  // The output register can take a new flit when empty or being drained.
  always_comb begin
    sel_valid_c = in_valid_i[gnt_idx_q];
    locked_c    = (state_q == LOCKED);
    free_c      = !out_valid_q || out_ready_i;
    xfer_c      = locked_c && free_c && sel_valid_c;
    in_ready_o  = (locked_c && free_c) ? (ONE << gnt_idx_q) : '0;
  end

  // Arbitration FSM and registered output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tail_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A tail flit may still be waiting here; only drain it.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
          end
          if (any_c) begin
            state_q   <= LOCKED;
            gnt_idx_q <= pick_c;
            grant_q   <= ONE << pick_c;
            busy_q    <= 1'b1;
          end
        end
        LOCKED: begin
          if (xfer_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data_c;
            out_tail_q  <= sel_tail_c;
            if (sel_tail_c) begin
              state_q  <= IDLE;
              rr_ptr_q <= gnt_idx_q;
              grant_q  <= '0;
              busy_q   <= 1'b0;
            end
          end else if (free_c) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tail_o  = out_tail_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rt_output_arbiter.sv
// tb_rt_output_arbiter: directed and random checks of rt_output_arbiter
// (n=32, N_REQ=4) against a reference model of owner, round-robin order and
// the output holding register.
module tb_rt_output_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   in_valid = '0;
  logic [NR*W-1:0] in_data = '0;
  logic [NR-1:0]   in_tail = '0;
  logic [NR-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_tail;
  logic            out_ready = 1'b0;
  logic [NR-1:0]   grant;
  logic            busy;

  rt_output_arbiter #(.n(W), .N_REQ(NR)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_tail_i  (in_tail),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_tail_o (out_tail),
    .out_ready_i(out_ready),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the output (-1 = nobody), last packet winner,
  // and the flit sitting in the output register.
  int          m_owner;
  int          m_rr;
  logic        m_ov;
  logic [31:0] m_od;
  logic        m_ot;

  // Traffic sources: per-requester flit sequence number, position in packet
  // and packet length.
  int seq  [NR];
  int pos  [NR];
  int plen [NR];
  bit rand_mode = 1'b0;

  logic [NR-1:0] prev_grant = '0;
  int            order_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = NR - 1;
    m_ov    = 1'b0;
    m_od    = '0;
    m_ot    = 1'b0;
    for (int i = 0; i < NR; i++) pos[i] = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge using the inputs that the DUT sampled.
  task automatic cycle();
    int            acc;
    logic          free;
    logic [NR-1:0] er;
    logic [NR-1:0] eg;
    @(negedge clk);
    free = !m_ov || out_ready;
    er = '0;
    eg = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (free) er[m_owner] = 1'b1;
    end
    chk("in_ready",  32'(in_ready),  32'(er));
    chk("grant",     32'(grant),     32'(eg));
    chk("busy",      32'(busy),      32'(m_owner >= 0));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  out_data,       m_od);
    chk("out_tail",  32'(out_tail),  32'(m_ot));
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NR; i++) if (grant[i]) order_q.push_back(i);
    prev_grant = grant;
    @(posedge clk);
    acc = -1;
    if (m_owner < 0) begin
      if (out_ready) m_ov = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (m_rr + k) % NR;
        if (in_valid[j]) begin
          m_owner = j;
          break;
        end
      end
    end else if (in_valid[m_owner] && free) begin
      acc  = m_owner;
      m_ov = 1'b1;
      m_od = in_data[m_owner*W +: W];
      m_ot = in_tail[m_owner];
      if (m_ot) begin
        m_rr    = m_owner;
        m_owner = -1;
      end
    end else if (free) begin
      m_ov = 1'b0;
    end
    if (acc >= 0) begin
      seq[acc]++;
      if (pos[acc] == plen[acc] - 1) begin
        pos[acc] = 0;
        if (rand_mode) plen[acc] = $urandom_range(1, 4);
      end else begin
        pos[acc]++;
      end
    end
    #1;
  endtask

  task automatic apply(input logic [NR-1:0] vmask, input logic ordy);
    in_valid  = vmask;
    out_ready = ordy;
    for (int i = 0; i < NR; i++) begin
      in_data[i*W +: W] = {8'(i), 24'(seq[i])};
      in_tail[i]        = (pos[i] == plen[i] - 1);
    end
    cycle();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    model_reset();
    prev_grant = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      seq[i]  = 16 * i;
      plen[i] = 1;
    end
    model_reset();

    // Reset with every requester valid: nothing accepted, nothing granted.
    #1 rst_n = 1'b0;
    in_valid = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_grant",     32'(grant),     32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    order_q.delete();
    apply(4'b1111, 1'b1);
    chk("first_grant", 32'(grant), 32'b0001);

    // Round-robin between single-flit packets.
    for (int c = 0; c < 11; c++) apply(4'b1111, 1'b1);
    chk("rr_count", 32'(order_q.size() >= 5), 32'd1);
    if (order_q.size() >= 5) begin
      chk("rr_order0", 32'(order_q[0]), 32'd0);
      chk("rr_order1", 32'(order_q[1]), 32'd1);
      chk("rr_order2", 32'(order_q[2]), 32'd2);
      chk("rr_order3", 32'(order_q[3]), 32'd3);
      chk("rr_order4", 32'(order_q[4]), 32'd0);
    end

    // Wormhole: port1 3-flit packet while port2 keeps requesting.
    do_reset();
    plen[1] = 3;
    plen[2] = 1;
    for (int c = 0; c < 8; c++) apply(4'b0110, 1'b1);

    // Backpressure mid-packet on port0.
    do_reset();
    plen[0] = 4;
    for (int c = 0; c < 3; c++) apply(4'b0001, 1'b1);
    for (int c = 0; c < 5; c++) apply(4'b0001, 1'b0);
    for (int c = 0; c < 6; c++) apply(4'b0001, 1'b1);

    // Owner stall: port3 goes quiet after its head flit, port0 waits.
    do_reset();
    plen[3] = 2;
    plen[0] = 1;
    for (int c = 0; c < 2; c++)  apply(4'b1000, 1'b1);
    for (int c = 0; c < 10; c++) apply(4'b0001, 1'b1);
    chk("stall_grant", 32'(grant), 32'b1000);
    for (int c = 0; c < 4; c++)  apply(4'b1001, 1'b1);

    // Asynchronous reset in the middle of a port2 packet.
    do_reset();
    plen[2] = 5;
    for (int c = 0; c < 4; c++) apply(4'b0100, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  out_data,       32'd0);
    chk("arst_out_tail",  32'(out_tail),  32'd0);
    chk("arst_grant",     32'(grant),     32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    prev_grant = '0;
    for (int i = 0; i < NR; i++) plen[i] = 1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(4'b1111, 1'b1);
    chk("arst_regrant", 32'(grant), 32'b0001);
    for (int c = 0; c < 4; c++) apply(4'b1111, 1'b1);

    // Random traffic with random packet lengths and backpressure.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < NR; i++) plen[i] = $urandom_range(1, 4);
    for (int c = 0; c < 1500; c++)
      apply(4'($urandom), ($urandom_range(0, 9) < 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
